// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: start delay, memory back-pressure, stall, redirect, fetch counter.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_gen #(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(32'h0),
   parameter int                INC         = 4,
   parameter int                START_DELAY = 1,
   parameter int                CNT_W       = 16,
   parameter logic [ADDR_W-1:0] TRAP_VEC    = ADDR_W'(32'h0000_0100)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_addr_i,
   input  logic              imem_ready_i,
   output logic [ADDR_W-1:0] pc,
   output logic              ce,
   output logic              flush_o,
   output logic [CNT_W-1:0]  fetch_cnt_o,
   output logic              misalign_o
);

   localparam int DW = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
   localparam logic [DW-1:0] LAST = (START_DELAY > 1) ? DW'(START_DELAY - 1) : '0;

   typedef enum logic [1:0] {START, RUN, HOLD} state_t;

   state_t            state;
   logic [DW-1:0]     dly;
   logic              accept;
   logic [ADDR_W-1:0] redir_pc;

   assign accept = ce & imem_ready_i & ~stall_i & ~redirect_i;

`ifdef PC_MISALIGN_TRAP_EN
   logic redir_bad;
   logic misalign_q;

   assign redir_bad  = |redirect_addr_i[1:0];
   assign redir_pc   = redir_bad ? TRAP_VEC : (redirect_addr_i & ~ADDR_W'(3));
   assign misalign_o = misalign_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         misalign_q <= 1'b0;
      else
         misalign_q <= redirect_i & redir_bad & (state != START);
   end
`else
   assign redir_pc   = redirect_addr_i & ~ADDR_W'(3);
   assign misalign_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= START;
         dly         <= '0;
         pc          <= RESET_VEC;
         ce          <= 1'b0;
         flush_o     <= 1'b0;
         fetch_cnt_o <= '0;
      end else begin
         flush_o <= 1'b0;
         if (redirect_i) begin
            pc <= redir_pc;
         end else if (accept) begin
            pc <= pc + ADDR_W'(INC);
            if (fetch_cnt_o != '1)
               fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
         end
         case (state)
            START: begin
               // a redirect here only preloads pc; nothing is in flight to flush
               if (dly == LAST) begin
                  state <= RUN;
                  ce    <= 1'b1;
               end else begin
                  dly <= dly + DW'(1);
               end
            end
            RUN, HOLD: begin
               flush_o <= redirect_i;
               state   <= stall_i ? HOLD : RUN;
            end
            default: state <= START;
         endcase
      end
   end

endmodule
